mac_shift_add: RTL
==================

# mac_shift_add

Parametrised sequential multiply-accumulate unit for the MAC datapath. Multiplies two unsigned WIDTH-bit operands one bit per cycle, forming each partial product with a bitwise AND gate stage, and adds the product into a running accumulator. It sits between the operand source (valid/ready handshake) and the result consumer (one-cycle valid pulse). The sticky overflow flag and clear input let software run bounded dot products.

## Interface
- WIDTH, 8: operand width in bits (≥2).
- ACC_WIDTH, 2*WIDTH+4: accumulator width in bits (≥2*WIDTH).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b present.
- in_ready  out  1  block can accept operands (IDLE only).
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- clear  in  1  zero accumulator and overflow (see Operation).
- out_valid  out  1  one-cycle pulse: acc holds a newly accumulated value.
- acc  out  ACC_WIDTH  accumulator, registered.
- overflow  out  1  sticky: set on accumulator carry-out.

## Operation
- States: IDLE, MUL, ACC.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b; product←0; count←0; go to MUL.
- MUL: each cycle, product += (a_latched AND {WIDTH{b_latched[count]}}) << count; count++. After WIDTH cycles (count=WIDTH-1 processed), go to ACC.
- ACC: {carry, acc} ← acc + zero-extended product (2*WIDTH bits); overflow ← overflow | carry; out_valid←1; go to IDLE.
- acc wraps modulo 2^ACC_WIDTH; overflow stays 1 until clear or reset.
- Latched operands only; a/b changes after the handshake have no effect. in_valid outside IDLE is ignored (no capture, no error).
- clear sampled every edge:
  - IDLE or MUL: acc←0, overflow←0; the in-flight multiply continues.
  - ACC edge: acc←product (old acc discarded), overflow←0, out_valid←1.
  - clear together with a handshake in IDLE: both take effect (acc←0 and operands captured).
- Reset: asynchronous, in any state; an in-flight operation is abandoned, with no out_valid pulse for it.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, acc=0, overflow=0, internal product/count=0.
- Handshake edge E0; MUL edges E1..E_WIDTH; ACC edge E_(WIDTH+1) updates acc/overflow and raises out_valid.
- out_valid is high for exactly the cycle after E_(WIDTH+1). in_ready is also high in that cycle.
- Earliest next handshake is edge E_(WIDTH+2). Throughput is one operation per WIDTH+2 cycles.
- acc and overflow change only on the ACC edge, on clear, or on reset.
- out_valid never stays high for two consecutive cycles.

## Test plan
- Reset: hold rst_n=0 mid-stream, then release -> acc=0, overflow=0, out_valid=0, in_ready=1 on the first cycle.
- Basic (WIDTH=8, ACC_WIDTH=20): a=3, b=5 accepted at E0 -> out_valid pulses after E9, acc=15, in_ready low from E1 through E9.
- Accumulate and hold: 255×255 twice -> acc=65025 then 130050. Toggle a/b and in_valid during MUL -> no effect, exactly two out_valid pulses.
- Overflow: 17 back-to-back ops of 255×255 from acc=0 -> after the 16th, acc=1040400 with overflow=0; after the 17th, acc=56849 with overflow=1. Overflow persists through a further op of 1×1 (acc=56850).
- Clear: clear=1 for one cycle during MUL of 7×9 with prior acc=100 -> acc=63 at out_valid, overflow=0. Clear in IDLE with no handshake -> acc=0 next cycle, no out_valid.
- Reset mid-operation: start 200×200, assert rst_n=0 at E4 -> outputs return to their reset values immediately, no out_valid afterwards. A following 2×3 -> acc=6.

Source files
------------

// File: rtl/mac_shift_add.sv
// Sequential shift-and-add multiply-accumulate: one multiplier bit per cycle,
// product summed into a wrapping accumulator with a sticky carry-out flag.
module mac_shift_add #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 2*WIDTH+4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clear,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   partial;
    logic [ACC_WIDTH:0]   acc_sum;

    // Partial product: AND gate stage on the current multiplier bit, aligned by count.
    always_comb begin
        partial = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[count_q]}}} << count_q;
        acc_sum = {1'b0, acc} + (ACC_WIDTH+1)'(product_q);
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                if (count_q == LAST) state_d = ACC;
            end
            ACC: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        product_q <= '0;
                        count_q   <= '0;
                    end
                end
                MUL: begin
                    product_q <= product_q + partial;
                    count_q   <= count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // A clear on the ACC edge replaces the accumulator with this product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_q == ACC);
            if (state_q == ACC) begin
                if (clear) begin
                    acc      <= ACC_WIDTH'(product_q);
                    overflow <= 1'b0;
                end else begin
                    acc      <= acc_sum[ACC_WIDTH-1:0];
                    overflow <= overflow | acc_sum[ACC_WIDTH];
                end
            end else if (clear) begin
                acc      <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule
